// File: rtl/pacman_snd_pkg.sv
// rtl/pacman_snd_pkg.sv - shared types and constants for the sound ROM blocks
package pacman_snd_pkg;

  localparam int SND_ADDR_W = 7;
  localparam int SND_DATA_W = 9;

  // A ROM word of all ones marks the end of an effect table.
  localparam logic [SND_DATA_W-1:0] SND_SENTINEL = 9'd511;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH1 = 2'd1,
    ST_FETCH2 = 2'd2,
    ST_PLAY   = 2'd3
  } snd_state_t;

endpackage

// File: rtl/pacman_tone_gen.sv
// rtl/pacman_tone_gen.sv - half-period counter driving a square-wave tone
// A zero half_period while enabled silences the output (rest / stop).
module pacman_tone_gen #(
  parameter int HP_W = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            tone
);

  logic [HP_W-1:0] cnt;
  logic            silent;
  logic            wrap;

  assign silent = (half_period == '0);
  assign wrap   = (cnt == half_period - HP_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else begin
      if (clear || (enable && silent)) begin
        cnt <= '0;
      end else if (enable) begin
        cnt <= wrap ? '0 : cnt + HP_W'(1);
      end

      // Tone level is not touched by clear, so phase carries across entries.
      if (enable && silent) begin
        tone <= 1'b0;
      end else if (enable && !clear && wrap) begin
        tone <= ~tone;
      end
    end
  end

endmodule

// File: rtl/pacman_sfx_player.sv
// rtl/pacman_sfx_player.sv - sound-effect ROM sequencer and tone player
// Optional macro SFX_RETRIGGER_EN: start while busy restarts playback from address 0.
module pacman_sfx_player
  import pacman_snd_pkg::*;
#(
  parameter int ADDR_W      = SND_ADDR_W,
  parameter int DATA_W      = SND_DATA_W,
  parameter int LAST_ADDR   = 122,
  parameter int STEP_CYCLES = 200000,
  parameter int TONE_SCALE  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              tone,
  output logic              busy,
  output logic              done
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HP_W   = DATA_W + $clog2(TONE_SCALE);

  snd_state_t        state;
  snd_state_t        state_nxt;
  logic [DATA_W-1:0] period;
  logic [STEP_W-1:0] step_cnt;
  logic [HP_W-1:0]   half_period;

  logic is_sentinel;
  logic step_end;
  logic at_last;
  logic accept;
  logic retrig;

  logic load_start;
  logic capture;
  logic finish;
  logic advance;
  logic tg_clear;
  logic tg_enable;
  logic tg_silence;

  assign is_sentinel = (rom_data == DATA_W'(SND_SENTINEL));
  assign step_end    = (step_cnt == STEP_W'(STEP_CYCLES - 1));
  assign at_last     = (rom_addr == ADDR_W'(LAST_ADDR));
  // A start coinciding with the done pulse is dropped; it must be reissued.
  assign accept      = (state == ST_IDLE) && start && !done;

`ifdef SFX_RETRIGGER_EN
  assign retrig = start && (state != ST_IDLE);
`else
  assign retrig = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_FETCH1;
      ST_FETCH1: state_nxt = ST_FETCH2;
      ST_FETCH2: state_nxt = is_sentinel ? ST_IDLE : ST_PLAY;
      ST_PLAY:   if (step_end) state_nxt = at_last ? ST_IDLE : ST_FETCH1;
      default:   state_nxt = ST_IDLE;
    endcase
    if (retrig) state_nxt = ST_FETCH1;
  end

  always_comb begin
    load_start = accept || retrig;
    capture    = 1'b0;
    finish     = 1'b0;
    advance    = 1'b0;
    tg_clear   = retrig;
    tg_enable  = retrig;
    tg_silence = retrig;
    if (!retrig) begin
      case (state)
        ST_FETCH2: begin
          capture    = 1'b1;
          finish     = is_sentinel;
          tg_clear   = !is_sentinel;
          tg_enable  = is_sentinel;
          tg_silence = is_sentinel;
        end
        ST_PLAY: begin
          finish     = step_end && at_last;
          advance    = step_end && !at_last;
          tg_enable  = 1'b1;
          tg_silence = step_end && at_last;
        end
        default: ;
      endcase
    end
  end

  // Forcing a zero half-period is how stop and retrigger drive tone low.
  assign half_period = tg_silence ? '0 : HP_W'(period) * HP_W'(TONE_SCALE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      period   <= '0;
      step_cnt <= '0;
    end else begin
      done <= finish;
      if (load_start) begin
        rom_addr <= '0;
        busy     <= 1'b1;
      end else if (advance) begin
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      if (finish) busy <= 1'b0;
      if (capture) period <= rom_data;
      if (tg_clear) begin
        step_cnt <= '0;
      end else if (state == ST_PLAY) begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  pacman_tone_gen #(
    .HP_W(HP_W)
  ) u_tone_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (tg_clear),
    .enable     (tg_enable),
    .half_period(half_period),
    .tone       (tone)
  );

endmodule

// File: tb/tb_pacman_sfx_player.sv
// tb/tb_pacman_sfx_player.sv - self-checking bench for pacman_sfx_player
module tb_pacman_sfx_player;

  localparam int STEP  = 8;
  localparam int SCALE = 1;
  localparam int MAXC  = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [6:0] rom_addr_a, rom_addr_b;
  logic [8:0] rom_data_a = '0;
  logic [8:0] rom_data_b = '0;
  logic       tone_a, busy_a, done_a;
  logic       tone_b, busy_b, done_b;

  logic [8:0] rom_a [128];
  logic [8:0] rom_b [128];

  int vecs = 0;
  int errs = 0;

  int exp_tone [MAXC];
  int exp_busy [MAXC];
  int exp_done [MAXC];
  int exp_addr [MAXC];
  int exp_chk  [MAXC];
  int mrom [128];
  int mlast;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
  end

  pacman_sfx_player #(
    .ADDR_W(7), .DATA_W(9), .LAST_ADDR(122), .STEP_CYCLES(STEP), .TONE_SCALE(SCALE)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .tone(tone_a), .busy(busy_a), .done(done_a)
  );

  pacman_sfx_player #(
    .ADDR_W(7), .DATA_W(9), .LAST_ADDR(2), .STEP_CYCLES(STEP), .TONE_SCALE(SCALE)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .tone(tone_b), .busy(busy_b), .done(done_b)
  );

  // Expected trace for a playback started at edge s; index k is the cycle after edge k.
  function automatic int model(input int s);
    int i, addr, p, tv;
    for (int k = s + 1; k < MAXC; k++) begin
      exp_tone[k] = 0; exp_busy[k] = 0; exp_done[k] = 0; exp_addr[k] = 0; exp_chk[k] = 0;
    end
    tv = 0; addr = 0; i = s + 1;
    while (i + 10 < MAXC) begin
      for (int c = 0; c < 2; c++) begin
        exp_busy[i+c] = 1; exp_tone[i+c] = tv; exp_addr[i+c] = addr; exp_chk[i+c] = 1;
      end
      if (mrom[addr] == 511) begin
        exp_done[i+2] = 1;
        return i + 2;
      end
      p = mrom[addr] * SCALE;
      for (int j = 0; j < STEP; j++) begin
        exp_busy[i+2+j] = 1; exp_addr[i+2+j] = addr; exp_chk[i+2+j] = 1;
        if (j == 0)      exp_tone[i+2+j] = tv;
        else if (p == 0) exp_tone[i+2+j] = 0;
        else             exp_tone[i+2+j] = tv ^ ((j / p) % 2);
      end
      tv = (p == 0) ? 0 : tv ^ ((STEP / p) % 2);
      if (addr == mlast) begin
        exp_done[i+2+STEP] = 1;
        return i + 2 + STEP;
      end
      addr++;
      i += 2 + STEP;
    end
    return MAXC - 4;
  endfunction

  task automatic load_a_table();
    for (int k = 0; k < 128; k++) rom_a[k] = 9'd511;
    rom_a[0] = 9'd3; rom_a[1] = 9'd0; rom_a[2] = 9'd2; rom_a[3] = 9'd511;
    for (int k = 0; k < 128; k++) mrom[k] = int'(rom_a[k]);
    mlast = 122;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({done_a, busy_a, tone_a, rom_addr_a} !== 10'd0) begin
      errs++; $display("FAIL reset_a done/busy/tone/addr=%b want 0", {done_a, busy_a, tone_a, rom_addr_a});
    end
    vecs++;
    if ({done_b, busy_b, tone_b, rom_addr_b} !== 10'd0) begin
      errs++; $display("FAIL reset_b done/busy/tone/addr=%b want 0", {done_b, busy_b, tone_b, rom_addr_b});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e, first_done;
    logic [2:0] want;
    load_a_table();
    e = model(0);
    first_done = -1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 1; i <= e + 3; i++) begin
      want = 3'(exp_done[i] * 4 + exp_busy[i] * 2 + exp_tone[i]);
      vecs++;
      if ({done_a, busy_a, tone_a} !== want) begin
        errs++; $display("FAIL basic cyc %0d done/busy/tone=%b want %b", i, {done_a, busy_a, tone_a}, want);
      end
      if (exp_chk[i] != 0) begin
        vecs++;
        if (rom_addr_a !== 7'(exp_addr[i])) begin
          errs++; $display("FAIL basic_addr cyc %0d got %0d want %0d", i, rom_addr_a, exp_addr[i]);
        end
      end
      if (done_a === 1'b1 && first_done < 0) first_done = i;
      @(negedge clk);
    end
    vecs++;
    if (first_done != 33) begin
      errs++; $display("FAIL basic_done_time got %0d want 33", first_done);
    end
  endtask

  task automatic test_last_addr(input bit randomize_rom);
    int e, first_done;
    logic [2:0] want;
    for (int k = 0; k < 128; k++) rom_b[k] = 9'($urandom_range(0, 9));
    if (!randomize_rom) begin
      rom_b[0] = 9'd3; rom_b[1] = 9'd0; rom_b[2] = 9'd2;
    end
    for (int k = 0; k < 128; k++) mrom[k] = int'(rom_b[k]);
    mlast = 2;
    e = model(0);
    first_done = -1;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int i = 1; i <= e + 3; i++) begin
      want = 3'(exp_done[i] * 4 + exp_busy[i] * 2 + exp_tone[i]);
      vecs++;
      if ({done_b, busy_b, tone_b} !== want) begin
        errs++; $display("FAIL last_addr cyc %0d done/busy/tone=%b want %b", i, {done_b, busy_b, tone_b}, want);
      end
      vecs++;
      if (rom_addr_b > 7'd2 || (exp_chk[i] != 0 && rom_addr_b !== 7'(exp_addr[i]))) begin
        errs++; $display("FAIL last_addr_addr cyc %0d got %0d want %0d", i, rom_addr_b, exp_addr[i]);
      end
      if (done_b === 1'b1 && first_done < 0) first_done = i;
      @(negedge clk);
    end
    vecs++;
    if (first_done != 31) begin
      errs++; $display("FAIL last_addr_done_time got %0d want 31", first_done);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    logic [2:0] want;
    load_a_table();
    e = model(0);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      want = 3'(exp_done[i] * 4 + exp_busy[i] * 2 + exp_tone[i]);
      vecs++;
      if ({done_a, busy_a, tone_a} !== want) begin
        errs++; $display("FAIL reset_mid_pre cyc %0d done/busy/tone=%b want %b", i, {done_a, busy_a, tone_a}, want);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vecs++;
    if ({done_a, busy_a, tone_a, rom_addr_a} !== 10'd0) begin
      errs++; $display("FAIL reset_mid done/busy/tone/addr=%b want 0", {done_a, busy_a, tone_a, rom_addr_a});
    end
    for (int i = 0; i < e; i++) begin
      @(negedge clk);
      vecs++;
      if ({done_a, busy_a, tone_a} !== 3'b000) begin
        errs++; $display("FAIL reset_mid_after cyc %0d done/busy/tone=%b want 000", i, {done_a, busy_a, tone_a});
      end
    end
  endtask

  task automatic test_start_while_busy();
    int e;
    logic [2:0] want;
    load_a_table();
    e = model(0);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 1; i <= e + 3; i++) begin
      want = 3'(exp_done[i] * 4 + exp_busy[i] * 2 + exp_tone[i]);
      vecs++;
      if ({done_a, busy_a, tone_a} !== want) begin
        errs++; $display("FAIL busy_start cyc %0d done/busy/tone=%b want %b", i, {done_a, busy_a, tone_a}, want);
      end
      if (exp_chk[i] != 0) begin
        vecs++;
        if (rom_addr_a !== 7'(exp_addr[i])) begin
          errs++; $display("FAIL busy_start_addr cyc %0d got %0d want %0d", i, rom_addr_a, exp_addr[i]);
        end
      end
      if (i == 15) begin
        start_a = 1'b1;
`ifdef SFX_RETRIGGER_EN
        e = model(15);
`endif
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sentinel_first();
    int first_done;
    for (int k = 0; k < 128; k++) rom_a[k] = 9'd511;
    first_done = -1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      vecs++;
      if (tone_a !== 1'b0 || (i < 3 && busy_a !== 1'b1) || (i >= 3 && busy_a !== 1'b0)) begin
        errs++; $display("FAIL sentinel_first cyc %0d tone=%b busy=%b", i, tone_a, busy_a);
      end
      if (done_a === 1'b1 && first_done < 0) first_done = i;
      @(negedge clk);
    end
    vecs++;
    if (first_done != 3) begin
      errs++; $display("FAIL sentinel_first_done_time got %0d want 3", first_done);
    end
  endtask

  task automatic test_start_on_done();
    int e;
    load_a_table();
    e = model(0);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 1; i <= e + 6; i++) begin
      if (i > e) begin
        vecs++;
        if (busy_a !== 1'b0 || done_a !== 1'(exp_done[i])) begin
          errs++; $display("FAIL start_on_done cyc %0d busy=%b done=%b want busy 0", i, busy_a, done_a);
        end
      end
      start_a = (i == e) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_random_a();
    int e, n;
    logic [2:0] want;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 5);
      for (int k = 0; k < 128; k++) rom_a[k] = 9'd511;
      for (int k = 0; k < n; k++) rom_a[k] = 9'($urandom_range(0, 9));
      for (int k = 0; k < 128; k++) mrom[k] = int'(rom_a[k]);
      mlast = 122;
      e = model(0);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      for (int i = 1; i <= e + 3; i++) begin
        want = 3'(exp_done[i] * 4 + exp_busy[i] * 2 + exp_tone[i]);
        vecs++;
        if ({done_a, busy_a, tone_a} !== want) begin
          errs++; $display("FAIL random it %0d cyc %0d done/busy/tone=%b want %b", it, i, {done_a, busy_a, tone_a}, want);
        end
        if (exp_chk[i] != 0) begin
          vecs++;
          if (rom_addr_a !== 7'(exp_addr[i])) begin
            errs++; $display("FAIL random_addr it %0d cyc %0d got %0d want %0d", it, i, rom_addr_a, exp_addr[i]);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 128; k++) begin
      rom_a[k] = 9'd511;
      rom_b[k] = 9'd511;
    end
    test_reset();
    test_basic();
    test_last_addr(1'b0);
    test_reset_mid();
    test_start_while_busy();
    test_sentinel_first();
    test_start_on_done();
    test_random_a();
    for (int it = 0; it < 4; it++) test_last_addr(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
